bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Produces the four BCD digit buses (ones/tens/hundreds/thousands) consumed by the 4-digit multiplexed seven-segment driver on the Basys3 board.
- Accepts one unsigned binary value per start pulse and converts it over BIN_W cycles.
- Holds the last result stable on its outputs so the display never shows intermediate digits.

Parameters:
- BIN_W, 14, width of the binary input; legal range 4..14; max 14 covers 0..16383.

Ports:
- clk  input  1  system clock (100 MHz on board)
- clr  input  1  asynchronous active-high reset
- start  input  1  conversion request, sampled on rising clk
- bin  input  BIN_W  unsigned binary value, captured when start is accepted
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new digits are valid
- ones  output  4  BCD units digit
- tens  output  4  BCD tens digit
- hundreds  output  4  BCD hundreds digit
- thousands  output  4  BCD thousands digit

Behaviour:
- Reset: clr high asynchronously forces state IDLE, busy=0, done=0, all four digit outputs=4'd0, and the internal shift registers to 0.
- States:
  - IDLE: busy=0. start=1 at edge E0 captures bin into the shift register, clears the 20-bit internal BCD accumulator (5 nibbles), loads the iteration counter with BIN_W, and moves to SHIFT.
  - SHIFT: busy=1. Each edge does the following:
    - adds 3 to every accumulator nibble >= 5;
    - shifts {accumulator, shift register} left by 1;
    - decrements the counter.
  - SHIFT exit: on the edge where the counter reaches 0 (edge E_BIN_W), the block registers the final nibbles onto the outputs, pulses done=1 for one cycle, and returns to IDLE.
- Latency:
  - done is high in the cycle following edge E_BIN_W, i.e. BIN_W+1 edges after start is sampled (15 for the default).
  - busy is high for exactly BIN_W cycles.
- Outputs:
  - Digit outputs change only on the done edge.
  - Between conversions they hold the previous result.
- start while busy=1: ignored, with no queuing and no effect on the conversion in progress.
- start in the done cycle: accepted (state is IDLE); back-to-back conversions run with no gap.
- bin changes after capture: no effect on the conversion in progress.
- Overflow for BIN_W=14 and bin >= 10000:
  - The 5th (ten-thousands) nibble is internal only.
  - Default behaviour: output the low four digits, e.g. 16383 gives thousands..ones = 6,3,8,3.
- clr mid-conversion: the conversion is aborted with no done pulse, and outputs return to 0.

Optional Feature:
- Macro BIN2BCD_OVF_DASH_EN.
- When defined:
  - A nonzero 5th nibble at completion forces all four digit outputs to 4'hF.
  - The driver renders 4'hF as a dash on each digit.
  - done still pulses with normal timing.
- When undefined: the low four digits are output (truncation), as described under Behaviour.

Test Plan:
- After clr, start with bin=1234 -> busy high 14 cycles; done pulses at the 15th edge; digits thousands..ones = 1,2,3,4.
- bin=0, then bin=9999 back-to-back, with start asserted in the done cycle -> digits 0,0,0,0 then 9,9,9,9; the second done arrives exactly 15 edges after the first.
- bin=10000 and bin=16383 -> without macro, digits 0,0,0,0 and 6,3,8,3; with BIN2BCD_OVF_DASH_EN, all digits 4'hF for both.
- Start at 42, pulse start again with bin=77 at cycle 5 of busy -> second start ignored; digits 0,0,4,2; only one done pulse.
- Start at 4321 from previous result 1234, assert clr at cycle 7 of busy -> busy=0 and digits 0 immediately; no done pulse; a fresh start at 4321 then yields 4,3,2,1.
- BIN_W=8, bin=255 -> done at 9th edge after start; digits 0,2,5,5.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary to 4-digit BCD converter.
// Optional BIN2BCD_OVF_DASH_EN: a nonzero ten-thousands digit shows dashes (4'hF) on all digits.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sr, sr_nxt;
  logic [19:0]        acc, acc_nxt, acc_shift;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        dig, dig_nxt;
  logic               done_nxt;

  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
    end
    return r;
  endfunction

`ifdef BIN2BCD_OVF_DASH_EN
  function automatic logic [15:0] dash_on_ovf(input logic [19:0] a);
    return (a[19:16] != 4'd0) ? 16'hFFFF : a[15:0];
  endfunction
`endif

  // One double-dabble step: correct nibbles, then shift the next binary MSB in
  assign acc_shift = (add3(acc) << 1) | {19'd0, sr[BIN_W-1]};

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    dig_nxt   = dig;
    done_nxt  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt    = bin;
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(BIN_W);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        acc_nxt = acc_shift;
        sr_nxt  = sr << 1;
        cnt_nxt = cnt - CNT_W'(1);
        // Last step: publish the just-shifted digits in the same edge
        if (cnt == CNT_W'(1)) begin
`ifdef BIN2BCD_OVF_DASH_EN
          dig_nxt = dash_on_ovf(acc_shift);
`else
          dig_nxt = acc_shift[15:0];
`endif
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr   <= '0;
      acc  <= '0;
      cnt  <= '0;
      dig  <= '0;
      done <= 1'b0;
    end else begin
      sr   <= sr_nxt;
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      dig  <= dig_nxt;
      done <= done_nxt;
    end
  end

  assign ones      = dig[3:0];
  assign tens      = dig[7:4];
  assign hundreds  = dig[11:8];
  assign thousands = dig[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits and done cycle are queued at start,
// a negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;
  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             clr, start, busy, done;
  logic [BIN_W-1:0] bin;
  logic [3:0]       ones, tens, hundreds, thousands;
  logic             start8, busy8, done8;
  logic [7:0]       bin8;
  logic [3:0]       ones8, tens8, hundreds8, thousands8;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] dig;
    int          cyc;
  } exp_t;
  exp_t q[$];

  bin2bcd_seq #(.BIN_W(BIN_W)) u_dut (
    .clk(clk), .clr(clr), .start(start), .bin(bin), .busy(busy), .done(done),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
  );

  bin2bcd_seq #(.BIN_W(8)) u_dut8 (
    .clk(clk), .clr(clr), .start(start8), .bin(bin8), .busy(busy8), .done(done8),
    .ones(ones8), .tens(tens8), .hundreds(hundreds8), .thousands(thousands8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: decimal digits by plain division
  function automatic logic [15:0] ref_bcd(input int v);
    int m;
`ifdef BIN2BCD_OVF_DASH_EN
    if (v >= 10000) return 16'hFFFF;
`endif
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int   busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL spurious_done: got done=1 expected no done (cycle %0d, digits %0h)", cyc, digits());
          end else begin
            e = q.pop_front();
            check("digits", digits(), e.dig);
            check("done_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, BIN_W);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input int v, input bit accepted);
    start = 1'b1;
    bin   = BIN_W'(v);
    if (accepted) q.push_back('{ref_bcd(v), cyc + 1 + BIN_W});
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = BIN_W'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int k, n, v;
    clr = 1'b1; start = 1'b0; bin = '0; start8 = 1'b0; bin8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_digits", digits(), 0);
    clr = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_digits", digits(), 0);

    issue(1234, 1'b1);
    wait_done();

    // Back-to-back with start in the done cycle
    @(posedge clk); #1;
    issue(0, 1'b1);
    wait_done();
    issue(9999, 1'b1);
    wait_done();

    @(posedge clk); #1;
    issue(10000, 1'b1);
    wait_done();
    issue(16383, 1'b1);
    wait_done();

    // Start during busy is ignored
    @(posedge clk); #1;
    issue(42, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    issue(77, 1'b0);
    wait_done();
    repeat (20) @(negedge clk);
    check("hold_digits", digits(), ref_bcd(42));

    // Abort with clr mid-conversion
    @(posedge clk); #1;
    issue(1234, 1'b1);
    wait_done();
    @(posedge clk); #1;
    issue(4321, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("pre_clr_busy", busy, 1);
    clr = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_digits", digits(), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (20) @(negedge clk);
    check("post_clr_digits", digits(), 0);
    @(posedge clk); #1;
    issue(4321, 1'b1);
    wait_done();

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, (1 << BIN_W) - 1));
      if (i % 4 == 0) begin
        @(posedge clk); #1;
      end
      issue(v, 1'b1);
      wait_done();
    end

    // Narrow instance
    @(posedge clk); #1;
    start8 = 1'b1; bin8 = 8'd255; k = cyc;
    @(posedge clk); #1;
    start8 = 1'b0; bin8 = 8'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 30);
    check("w8_done_cycle", cyc, k + 1 + 8);
    check("w8_digits", {thousands8, hundreds8, tens8, ones8}, 16'h0255);

    wait_drain();
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
